// File: rtl/twofish_block_io_if.sv
`default_nettype none
// ============================================================================
// twofish_block_io_if : word-serial I/O and datapath-side signal bundle
// Rev 1.0
// ============================================================================
interface twofish_block_io_if;
  logic [127:0] key_in;
  logic         key_load;
  logic [127:0] iv_in;
  logic         iv_load;
  logic         mode;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dp_block;
  logic [127:0] dp_key;
  logic         dp_start;
  logic         dp_ende;
  logic [127:0] dp_o;
  logic         dp_busy;

  // slave: the block_io core; master: the environment driving it
  modport slave (
    input  key_in, key_load, iv_in, iv_load, mode, in_data, in_valid,
           out_ready, dp_o, dp_busy,
    output in_ready, out_data, out_valid, dp_block, dp_key, dp_start, dp_ende
  );

  modport master (
    output key_in, key_load, iv_in, iv_load, mode, in_data, in_valid,
           out_ready, dp_o, dp_busy,
    input  in_ready, out_data, out_valid, dp_block, dp_key, dp_start, dp_ende
  );
endinterface
`default_nettype wire

// File: rtl/twofish_block_io.sv
`default_nettype none
// ============================================================================
// twofish_block_io : packs 4x32-bit words into a block for the Twofish
// datapath, handshakes Start/busy and streams the result back out.
// Optional CBC chaining when CBC_MODE_EN is defined (ECB otherwise).
// Rev 1.0
// ============================================================================
module twofish_block_io (
  input  logic               Clk,
  input  logic               Reset,
  twofish_block_io_if.slave  io
);

  typedef enum logic [2:0] {
    FILL    = 3'd0,
    START   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] key_q;
  logic [127:0] in_q;
  logic [127:0] res_q;
  logic [127:0] blk_q;
  logic         mode_q;

  logic         in_fire;
  logic         load_ok;
  logic         capture;
  logic [6:0]   word_lsb;
  logic [127:0] in_full;

  // word 0 sits in the top bits, so the slice base is (3 - cnt) * 32
  assign word_lsb = {~cnt_q, 5'b0};
  assign in_full  = {in_q[127:32], io.in_data};
  assign load_ok  = (state_q == FILL) && (cnt_q == 2'd0);
  assign capture  = (state_q == WAIT_LO) && !io.dp_busy;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= FILL;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    in_fire      = 1'b0;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    io.dp_start  = 1'b0;
    case (state_q)
      FILL: begin
        io.in_ready = 1'b1;
        if (io.in_valid) begin
          in_fire = 1'b1;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = START;
        end
      end
      START: begin
        io.dp_start = 1'b1;
        state_d     = WAIT_HI;
      end
      WAIT_HI: if (io.dp_busy)  state_d = WAIT_LO;
      WAIT_LO: if (!io.dp_busy) state_d = DRAIN;
      DRAIN: begin
        io.out_valid = 1'b1;
        if (io.out_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

`ifdef CBC_MODE_EN
  logic [127:0] chain_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      chain_q <= '0;
    end else if (load_ok && io.iv_load) begin
      chain_q <= io.iv_in;
    end else if (capture) begin
      // next block chains on the ciphertext in both directions
      chain_q <= mode_q ? in_q : io.dp_o;
    end
  end
`else
  logic unused_ecb;
  assign unused_ecb = ^{io.iv_in, io.iv_load, in_q[31:0]};
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      key_q  <= '0;
      in_q   <= '0;
      res_q  <= '0;
      blk_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      if (load_ok && io.key_load) key_q <= io.key_in;
      if (in_fire) begin
        in_q[word_lsb +: 32] <= io.in_data;
        if (cnt_q == 2'd0) mode_q <= io.mode;
        if (cnt_q == 2'd3) begin
`ifdef CBC_MODE_EN
          blk_q <= mode_q ? in_full : (in_full ^ chain_q);
`else
          blk_q <= in_full;
`endif
        end
      end
      if (capture) begin
`ifdef CBC_MODE_EN
        res_q <= mode_q ? (io.dp_o ^ chain_q) : io.dp_o;
`else
        res_q <= io.dp_o;
`endif
      end
    end
  end

  assign io.out_data = res_q[word_lsb +: 32];
  assign io.dp_block = blk_q;
  assign io.dp_key   = key_q;
  assign io.dp_ende  = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_twofish_block_io.sv
`default_nettype none
// Bench for twofish_block_io: stub datapath with a reversible toy cipher,
// block-level reference model and queue-based scoreboard.
module tb_twofish_block_io;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  twofish_block_io_if bus ();

  twofish_block_io dut (
    .Clk   (clk),
    .Reset (rst),
    .io    (bus)
  );

  typedef struct packed {
    logic [127:0] blk;
    logic [127:0] key;
    logic         ende;
  } start_t;

  int           checks = 0;
  int           errors = 0;
  logic [31:0]  exp_q[$];
  start_t       start_q[$];
  start_t       s;
  logic [127:0] m_key;
  logic [127:0] m_chain;
  int           force_delay = -1;
  int           force_len   = -1;
  int           bp_mode     = 0;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] toy_enc(input logic [127:0] b, input logic [127:0] k);
    logic [127:0] x;
    x = b ^ k;
    return {x[120:0], x[127:121]} ^ {k[63:0], k[127:64]};
  endfunction

  function automatic logic [127:0] toy_dec(input logic [127:0] c, input logic [127:0] k);
    logic [127:0] x;
    x = c ^ {k[63:0], k[127:64]};
    return {x[6:0], x[127:7]} ^ k;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},  {127'd0, bus.in_ready},  128'd1);
    chk({tag, "_out_valid"}, {127'd0, bus.out_valid}, 128'd0);
    chk({tag, "_dp_start"},  {127'd0, bus.dp_start},  128'd0);
    chk({tag, "_dp_ende"},   {127'd0, bus.dp_ende},   128'd0);
    chk({tag, "_dp_block"},  bus.dp_block,            128'd0);
    chk({tag, "_dp_key"},    bus.dp_key,              128'd0);
    chk({tag, "_out_data"},  {96'd0, bus.out_data},   128'd0);
  endtask

  // Stub datapath: junk on dp_o except exactly when busy falls
  initial begin
    int d;
    int l;
    logic [127:0] r;
    bus.dp_busy = 1'b0;
    bus.dp_o    = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.dp_start) begin
        d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 2));
        l = (force_len > 0) ? force_len : int'($urandom_range(1, 7));
        r = bus.dp_ende ? toy_dec(bus.dp_block, bus.dp_key) : toy_enc(bus.dp_block, bus.dp_key);
        bus.dp_o = rand128();
        for (int i = 0; i < d + l; i++) begin
          @(negedge clk);
          if (rst) break;
          bus.dp_busy = (i >= d);
        end
        if (!rst) begin
          @(negedge clk);
          bus.dp_busy = 1'b0;
          bus.dp_o    = r;
          @(negedge clk);
        end
        bus.dp_busy = 1'b0;
        bus.dp_o    = rand128();
      end
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      bus.out_ready = (bp_mode != 0) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a start or a word
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.dp_start) begin
          if (start_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL dp_start: got unexpected pulse, required none");
          end else begin
            s = start_q.pop_front();
            chk("dp_key",   bus.dp_key,   s.key);
            chk("dp_block", bus.dp_block, s.blk);
            chk("dp_ende",  {127'd0, bus.dp_ende}, {127'd0, s.ende});
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          chk("in_ready_drain", {127'd0, bus.in_ready}, 128'd0);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL out_word: got %h, required no output", bus.out_data);
          end else begin
            chk("out_word", {96'd0, bus.out_data}, {96'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  // Reference model works on whole blocks; pushes expectations then drives words
  task automatic send_block(input logic [127:0] p, input logic m,
                            input bit ldk, input logic [127:0] k,
                            input bit ldiv, input logic [127:0] iv,
                            input bit use_exp, input logic [127:0] exp_in,
                            output logic [127:0] res);
    logic [127:0] dpblk;
    int n;
    if (ldk) m_key = k;
`ifdef CBC_MODE_EN
    if (ldiv) m_chain = iv;
    if (!m) begin
      dpblk   = p ^ m_chain;
      res     = toy_enc(dpblk, m_key);
      m_chain = res;
    end else begin
      dpblk   = p;
      res     = toy_dec(p, m_key) ^ m_chain;
      m_chain = p;
    end
`else
    dpblk = p;
    res   = m ? toy_dec(p, m_key) : toy_enc(p, m_key);
`endif
    if (use_exp) res = exp_in;
    start_q.push_back('{dpblk, m_key, m});
    for (int w = 0; w < 4; w++) exp_q.push_back(res[127 - 32*w -: 32]);
    for (int w = 0; w < 4; w++) begin
      bus.in_valid = 1'b0;
      bus.key_load = 1'b0;
      bus.iv_load  = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      n = 0;
      while (!bus.in_ready && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (!bus.in_ready) begin
        checks++; errors++;
        $display("FAIL in_ready_timeout: got 0 after %0d cycles, required 1", n);
        return;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = p[127 - 32*w -: 32];
      bus.mode     = (w == 0) ? m : 1'($urandom_range(0, 1));
      bus.key_load = ldk && (w == 0);
      bus.key_in   = (w == 0) ? k : rand128();
      bus.iv_load  = ldiv && (w == 0);
      bus.iv_in    = (w == 0) ? iv : rand128();
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.key_load = 1'b0;
    bus.iv_load  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d words pending, required 0", exp_q.size());
    end
  endtask

  task automatic ignored_loads(input logic [127:0] k);
    int n;
    n = 0;
    while (!(bus.dp_busy && !bus.in_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.key_load = 1'b1;
    bus.key_in   = k;
    bus.iv_load  = 1'b1;
    bus.iv_in    = k;
    @(negedge clk);
    bus.key_load = 1'b0;
    bus.iv_load  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] p1, p2, c1, c2, ka, junk, iv;
    int n;
    rst          = 1'b1;
    bus.key_in   = '0;
    bus.key_load = 1'b0;
    bus.iv_in    = '0;
    bus.iv_load  = 1'b0;
    bus.mode     = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    m_key        = '0;
    m_chain      = '0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    @(negedge clk);

    // busy pulse of 1 cycle, then 7 cycles
    force_len = 1;
    send_block(rand128(), 1'b0, 1'b1, rand128(), 1'b0, '0, 1'b0, '0, junk);
    wait_drain();
    force_len = 7;
    send_block(rand128(), 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, junk);
    wait_drain();
    force_len = -1;

    // round trip: two encrypts, reload IV, decrypt back to plaintext
    iv = 128'h000102030405060708090a0b0c0d0e0f;
    p1 = rand128();
    p2 = rand128();
    send_block(p1, 1'b0, 1'b0, '0, 1'b1, iv, 1'b0, '0, c1);
    send_block(p2, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, c2);
    send_block(c1, 1'b1, 1'b0, '0, 1'b1, iv, 1'b1, p1, junk);
    send_block(c2, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, p2, junk);
    wait_drain();

    // out_ready pattern 1,0,0,1,0,0...
    bp_mode = 1;
    send_block(rand128(), 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, junk);
    send_block(rand128(), 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, junk);
    wait_drain();
    bp_mode = 0;

    // loads outside FILL/cnt=0 must be dropped
    ka = rand128();
    force_len = 4;
    send_block(rand128(), 1'b0, 1'b1, ka, 1'b0, '0, 1'b0, '0, junk);
    ignored_loads(rand128());
    force_len = -1;
    send_block(rand128(), 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, junk);
    wait_drain();

    for (int b = 0; b < 20; b++) begin
      send_block(rand128(), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), rand128(),
                 ($urandom_range(0, 3) == 0), rand128(), 1'b0, '0, junk);
    end
    wait_drain();

    // reset in WAIT_HI two cycles after dp_start
    force_delay = 5;
    send_block(rand128(), 1'b0, 1'b1, rand128(), 1'b1, rand128(), 1'b0, '0, junk);
    n = 0;
    while (!bus.dp_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("mid");
    exp_q.delete();
    start_q.delete();
    m_key   = '0;
    m_chain = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    force_delay = -1;
    @(negedge clk);
    send_block(rand128(), 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, junk);
    wait_drain();
    repeat (5) @(negedge clk);
    chk("start_q_empty", 128'(start_q.size()), 128'd0);
    chk("exp_q_empty",   128'(exp_q.size()),   128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
